// File: rtl/round_robin_fifo_distributor.sv
// Round-robin distributor: one write stream spread over four FIFOs, each
// drained by its own consumer through a registered output port.
module round_robin_fifo_distributor #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wen,
   input  logic [WIDTH-1:0] din,
   input  logic [3:0]       ren,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] d,
   output logic [3:0]       valid,
   output logic [3:0]       fifo_full,
   output logic             full_all,
   output logic             drop
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q  [4][DEPTH];
   logic [WIDTH-1:0] mem_d  [4][DEPTH];
   logic [AW-1:0]    wptr_q [4];
   logic [AW-1:0]    wptr_d [4];
   logic [AW-1:0]    rptr_q [4];
   logic [AW-1:0]    rptr_d [4];
   logic [CW-1:0]    cnt_q  [4];
   logic [CW-1:0]    cnt_d  [4];
   logic [WIDTH-1:0] out_q  [4];
   logic [WIDTH-1:0] out_d  [4];
   logic [1:0]       ptr_q;
   logic [1:0]       ptr_d;
   logic [3:0]       valid_q;
   logic [3:0]       valid_d;
   logic             drop_q;
   logic             drop_d;

   logic [3:0]       full_s;
   logic [3:0]       rd_s;
   logic [3:0]       wr_s;
   logic [1:0]       tgt_s;
   logic [1:0]       idx_s;
   logic             found_s;

   // Status from start-of-cycle counts and round-robin target selection.
   always_comb begin
      full_s  = 4'b0000;
      rd_s    = 4'b0000;
      wr_s    = 4'b0000;
      tgt_s   = ptr_q;
      idx_s   = 2'd0;
      found_s = 1'b0;
      for (int i = 0; i < 4; i++) begin
         full_s[i] = (cnt_q[i] == FULL_CNT);
         rd_s[i]   = ren[i] && (cnt_q[i] != {CW{1'b0}});
      end
      // Scan from farthest to nearest so the nearest non-full FIFO wins.
      for (int k = 3; k >= 0; k--) begin
         idx_s = ptr_q + 2'(k);
         if (!full_s[idx_s]) begin
            tgt_s   = idx_s;
            found_s = 1'b1;
         end else begin
            tgt_s   = tgt_s;
         end
      end
      if (wen && found_s) begin
         wr_s[tgt_s] = 1'b1;
      end else begin
         wr_s = 4'b0000;
      end
   end

   // Next-state for storage, pointers, counts, outputs and drop flag.
   always_comb begin
      mem_d  = mem_q;
      ptr_d  = ptr_q;
      drop_d = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wptr_d[i]  = wptr_q[i];
         rptr_d[i]  = rptr_q[i];
         cnt_d[i]   = cnt_q[i];
         out_d[i]   = {WIDTH{1'b0}};
         valid_d[i] = 1'b0;
         if (wr_s[i]) begin
            mem_d[i][wptr_q[i]] = din;
            wptr_d[i]           = wptr_q[i] + AW'(1);
         end else begin
            wptr_d[i] = wptr_q[i];
         end
         if (rd_s[i]) begin
            out_d[i]   = mem_q[i][rptr_q[i]];
            valid_d[i] = 1'b1;
            rptr_d[i]  = rptr_q[i] + AW'(1);
         end else begin
            rptr_d[i] = rptr_q[i];
         end
         case ({wr_s[i], rd_s[i]})
            2'b10:   cnt_d[i] = cnt_q[i] + CW'(1);
            2'b01:   cnt_d[i] = cnt_q[i] - CW'(1);
            default: cnt_d[i] = cnt_q[i];
         endcase
      end
      if (wen) begin
         if (found_s) begin
            ptr_d = tgt_s + 2'd1;
         end else begin
            drop_d = 1'b1;
         end
      end else begin
         ptr_d = ptr_q;
      end
   end

   // Control state register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q   <= 2'd0;
         valid_q <= 4'b0000;
         drop_q  <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            wptr_q[i] <= {AW{1'b0}};
            rptr_q[i] <= {AW{1'b0}};
            cnt_q[i]  <= {CW{1'b0}};
            out_q[i]  <= {WIDTH{1'b0}};
         end
      end else begin
         ptr_q   <= ptr_d;
         valid_q <= valid_d;
         drop_q  <= drop_d;
         for (int i = 0; i < 4; i++) begin
            wptr_q[i] <= wptr_d[i];
            rptr_q[i] <= rptr_d[i];
            cnt_q[i]  <= cnt_d[i];
            out_q[i]  <= out_d[i];
         end
      end
   end

   // FIFO storage; contents need no reset because counts gate every read.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign a         = out_q[0];
   assign b         = out_q[1];
   assign c         = out_q[2];
   assign d         = out_q[3];
   assign valid     = valid_q;
   assign fifo_full = full_s;
   assign full_all  = &full_s;
   assign drop      = drop_q;

endmodule

// File: tb/tb_round_robin_fifo_distributor.sv
// Scoreboard bench for round_robin_fifo_distributor: directed stimulus pushes
// expected popped data into per-port queues; a negedge monitor checks outputs.
module tb_round_robin_fifo_distributor;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wen = 1'b0;
   logic [7:0] din = 8'd0;
   logic [3:0] ren = 4'b0000;
   logic [7:0] a, b, c, d;
   logic [3:0] valid, fifo_full;
   logic       full_all, drop;

   logic [7:0] outs [4];
   logic [7:0] exp_q [4][$];
   logic [7:0] mon_e;
   int         checks = 0;
   int         failures = 0;

   round_robin_fifo_distributor #(.WIDTH(8), .DEPTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .wen(wen), .din(din), .ren(ren),
      .a(a), .b(b), .c(c), .d(d), .valid(valid),
      .fifo_full(fifo_full), .full_all(full_all), .drop(drop)
   );

   assign outs[0] = a;
   assign outs[1] = b;
   assign outs[2] = c;
   assign outs[3] = d;

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   // One clock of stimulus; inputs change 1 time unit after the edge.
   task automatic cyc(input logic w, input logic [7:0] dv, input logic [3:0] r);
      wen = w;
      din = dv;
      ren = r;
      @(posedge clk);
      #1;
      wen = 1'b0;
      ren = 4'b0000;
   endtask

   task automatic expect_pop(input int i, input logic [7:0] v);
      exp_q[i].push_back(v);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      wen   = 1'b0;
      ren   = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Idle one cycle so the monitor drains, then require empty queues.
   task automatic drained(input string nm);
      cyc(1'b0, 8'd0, 4'b0000);
      for (int i = 0; i < 4; i++) chk({nm, "_queue_left"}, exp_q[i].size(), 0);
   endtask

   // Monitor: every valid output must match the oldest expectation; idle outputs read 0.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 4; i++) begin
            if (valid[i]) begin
               chk("pop_was_expected", (exp_q[i].size() != 0), 1);
               if (exp_q[i].size() != 0) begin
                  mon_e = exp_q[i].pop_front();
                  chk("pop_data", outs[i], mon_e);
               end
            end else begin
               chk("idle_out_zero", outs[i], 0);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      do_reset();
      chk("rst_valid", valid, 4'b0000);
      chk("rst_full", fifo_full, 4'b0000);
      chk("rst_full_all", full_all, 1'b0);
      chk("rst_drop", drop, 1'b0);
      chk("rst_a", a, 8'd0);

      // 1: four writes rotate a,b,c,d; one parallel pop
      cyc(1'b1, 8'd87, 4'b0000);
      cyc(1'b1, 8'd56, 4'b0000);
      cyc(1'b1, 8'd9,  4'b0000);
      cyc(1'b1, 8'd12, 4'b0000);
      expect_pop(0, 8'd87); expect_pop(1, 8'd56);
      expect_pop(2, 8'd9);  expect_pop(3, 8'd12);
      cyc(1'b0, 8'd0, 4'b1111);
      chk("t1_valid", valid, 4'b1111);
      drained("t1");

      // 2: empty read pops nothing; later write then read returns it
      cyc(1'b0, 8'd0, 4'b0001);
      chk("t2_empty_valid", valid, 4'b0000);
      chk("t2_empty_a", a, 8'd0);
      cyc(1'b1, 8'd77, 4'b0000);
      expect_pop(0, 8'd77);
      cyc(1'b0, 8'd0, 4'b0001);
      chk("t2_valid", valid, 4'b0001);
      drained("t2");

      // 3: fill all, dropped write, pop b, refill b
      do_reset();
      for (int k = 0; k < 32; k++) cyc(1'b1, 8'(k), 4'b0000);
      chk("t3_full", fifo_full, 4'b1111);
      chk("t3_full_all", full_all, 1'b1);
      cyc(1'b1, 8'd200, 4'b0000);
      chk("t3_drop", drop, 1'b1);
      chk("t3_full_after_drop", fifo_full, 4'b1111);
      cyc(1'b0, 8'd0, 4'b0000);
      chk("t3_drop_clear", drop, 1'b0);
      expect_pop(1, 8'd1);
      cyc(1'b0, 8'd0, 4'b0010);
      chk("t3_b_not_full", fifo_full, 4'b1101);
      cyc(1'b1, 8'd99, 4'b0000);
      chk("t3_refull", full_all, 1'b1);
      chk("t3_no_drop", drop, 1'b0);
      for (int k = 1; k < 8; k++) expect_pop(1, 8'(1 + 4 * k));
      expect_pop(1, 8'd99);
      for (int k = 0; k < 8; k++) cyc(1'b0, 8'd0, 4'b0010);
      drained("t3");

      // 4: wrap of FIFO a, writes skip full FIFOs
      do_reset();
      for (int k = 0; k < 32; k++) cyc(1'b1, 8'(k), 4'b0000);
      for (int k = 0; k < 8; k++) begin
         expect_pop(0, 8'(4 * k));
         cyc(1'b0, 8'd0, 4'b0001);
      end
      chk("t4_a_empty", fifo_full, 4'b1110);
      for (int k = 32; k < 36; k++) cyc(1'b1, 8'(k), 4'b0000);
      chk("t4_a_partial", fifo_full, 4'b1110);
      chk("t4_no_drop", drop, 1'b0);
      for (int k = 32; k < 36; k++) begin
         expect_pop(0, 8'(k));
         cyc(1'b0, 8'd0, 4'b0001);
         chk("t4_valid_a", valid[0], 1'b1);
      end
      drained("t4");

      // 5: same-cycle write and read on empty FIFO a
      do_reset();
      cyc(1'b1, 8'd51, 4'b0001);
      chk("t5_same_cycle_valid", valid[0], 1'b0);
      expect_pop(0, 8'd51);
      cyc(1'b0, 8'd0, 4'b0001);
      drained("t5");

      // 6: reset mid-run discards data; next write goes to a
      do_reset();
      for (int k = 0; k < 16; k++) cyc(1'b1, 8'(100 + k), 4'b0000);
      rst_n = 1'b0;
      ren   = 4'b1111;
      @(posedge clk);
      #1;
      chk("t6_rst_valid", valid, 4'b0000);
      chk("t6_rst_full", fifo_full, 4'b0000);
      rst_n = 1'b1;
      ren   = 4'b0000;
      cyc(1'b1, 8'd85, 4'b0001);
      chk("t6_empty_same_cycle", valid, 4'b0000);
      expect_pop(0, 8'd85);
      cyc(1'b0, 8'd0, 4'b0001);
      cyc(1'b0, 8'd0, 4'b1111);
      chk("t6_old_data_gone", valid, 4'b0000);
      drained("t6");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
